// File: rtl/tdm_demux_1_8_pkg.sv
// Shared definitions for the TDM link: channel count defaults, FSM encoding
// and the slot-to-channel map used by both the mux and demux sides.
package tdm_demux_1_8_pkg;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned SEL_W_DEF  = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;
  localparam int unsigned CH_D = 3;
  localparam int unsigned CH_E = 4;
  localparam int unsigned CH_F = 5;
  localparam int unsigned CH_G = 6;
  localparam int unsigned CH_H = 7;

  typedef struct packed {
    logic din;
    logic din_valid;
    logic sync;
  } beat_t;

endpackage

// File: rtl/tdm_demux_1_8_if.sv
// Serial-in / parallel-out bundle between the TDM link receiver and its users.
interface tdm_demux_1_8_if
  import tdm_demux_1_8_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
);

  logic              din;
  logic              din_valid;
  logic              sync;
  logic [NUM_CH-1:0] ch_out;
  logic              frame_valid;
  logic              frame_err;
  logic [SEL_W-1:0]  slot;
  logic              locked;

  modport master (
    output din, din_valid, sync,
    input  ch_out, frame_valid, frame_err, slot, locked
  );

  modport slave (
    input  din, din_valid, sync,
    output ch_out, frame_valid, frame_err, slot, locked
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_CH slot counter: load to 1 on a sync beat, advance on a plain beat.
// Shared with the transmit side, where it drives the mux selects.
module tdm_slot_counter #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [SEL_W-1:0] o_slot
);

  logic [SEL_W-1:0] r_slot;

  // The sync beat itself occupies slot 0, so the next expected slot is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= SEL_W'(1);
    end else if (i_advance) begin
      r_slot <= (r_slot == SEL_W'(NUM_CH - 1)) ? '0 : r_slot + SEL_W'(1);
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux_1_8.sv
// 1:8 TDM demultiplexer: assembles a frame of serial beats in a shadow register
// and publishes all channels at once with a one-cycle frame strobe.
module tdm_demux_1_8
  import tdm_demux_1_8_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux_1_8_if.slave    bus
);

  logic [0:0]        r_state;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] r_ch_out;
  logic              r_frame_valid;
  logic              r_frame_err;

  beat_t             w_beat;
  logic [SEL_W-1:0]  w_slot;
  logic [SEL_W-1:0]  w_idx;
  logic              w_run;
  logic              w_start;
  logic              w_advance;
  logic              w_capture;
  logic              w_resync;
  logic              w_complete;

  assign w_beat     = {bus.din, bus.din_valid, bus.sync};
  assign w_run      = (r_state == ST_RUN);
  assign w_start    = w_beat.din_valid & w_beat.sync;
  assign w_advance  = w_run & w_beat.din_valid & ~w_beat.sync;
  assign w_capture  = w_start | w_advance;
  assign w_resync   = w_run & w_start & (w_slot != '0);
  // A sync beat always restarts at slot 0, so it can never complete a frame.
  assign w_complete = w_advance & (w_slot == SEL_W'(NUM_CH - 1));
  assign w_idx      = w_start ? '0 : w_slot;

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_start),
    .i_advance (w_advance),
    .o_slot    (w_slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_start) begin
      r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow[w_idx] <= w_beat.din;
    end
  end

  // The last beat bypasses the shadow so ch_out lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_out      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if (w_complete) begin
        r_ch_out <= {w_beat.din, r_shadow[NUM_CH-2:0]};
      end
      r_frame_valid <= w_complete;
      r_frame_err   <= w_resync;
    end
  end

  assign bus.ch_out      = r_ch_out;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.slot        = w_slot;
  assign bus.locked      = w_run;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Bench for tdm_demux_1_8: per-beat vector table plus scoreboarded frame sequences.
module tb_tdm_demux_1_8;

  logic clk;
  logic rst;

  tdm_demux_1_8_if #(.NUM_CH(8), .SEL_W(3)) bus ();

  tdm_demux_1_8 #(
    .NUM_CH (8),
    .SEL_W  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       dv;
    logic       sync;
    logic [7:0] ch;
    logic       fv;
    logic       fe;
    logic [2:0] slot;
    logic       lk;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] sb_q[$];
  int         fv_cyc[$];
  int         err_exp;
  int         n_vec;
  int         n_fail;
  int         cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every frame strobe must match a queued frame.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected_frame_valid", 32'(bus.ch_out), 32'hFFFF_FFFF);
      end else begin
        chk("frame_ch_out", 32'(bus.ch_out), 32'(sb_q.pop_front()));
      end
    end
    if (bus.frame_err === 1'b1) begin
      chk("frame_err_expected", 32'(err_exp > 0), 32'd1);
      if (err_exp > 0) err_exp--;
    end
    if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) begin
      chk("fv_fe_exclusive", 32'd1, 32'd0);
    end
  end

  task automatic beat(input logic d, input logic v, input logic s);
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int first, input bit sync_first,
                           input int gap);
    for (int i = first; i < 8; i++) begin
      if (i == 7) sb_q.push_back(b);
      beat(b[i], 1'b1, sync_first && (i == first));
      // Gap beats assert sync without din_valid; they must be ignored.
      if (i < 7) repeat (gap) beat(1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic add_vec(input logic d, input logic v, input logic s, input logic [7:0] ch,
                         input logic fv, input logic [2:0] sl, input logic lk);
    vec_t x;
    x.din = d; x.dv = v; x.sync = s; x.ch = ch; x.fv = fv; x.fe = 1'b0;
    x.slot = sl; x.lk = lk;
    vt.push_back(x);
  endtask

  initial begin
    logic [7:0] pat;
    n_vec = 0; n_fail = 0; err_exp = 0; cyc = 0;
    rst = 1'b1;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;

    // Test 1: beats without sync are dropped while idle.
    for (int i = 0; i < 8; i++) add_vec(1'(i), 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    // Test 2: one frame A..H = 1,0,1,1,0,0,1,0.
    pat = 8'h4D;
    for (int i = 0; i < 8; i++)
      add_vec(pat[i], 1'b1, 1'(i == 0), (i == 7) ? 8'h4D : 8'h00, 1'(i == 7),
              3'((i + 1) % 8), 1'b1);
    add_vec(1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {24'd0, bus.ch_out, bus.frame_valid, bus.frame_err, bus.slot, bus.locked},
        32'd0);
    rst = 1'b0;

    foreach (vt[k]) begin
      if (vt[k].fv) sb_q.push_back(vt[k].ch);
      beat(vt[k].din, vt[k].dv, vt[k].sync);
      chk($sformatf("vec%0d", k),
          {18'd0, bus.ch_out, bus.frame_valid, bus.frame_err, bus.slot, bus.locked},
          {18'd0, vt[k].ch, vt[k].fv, vt[k].fe, vt[k].slot, vt[k].lk});
    end

    // Test 3: same frame with 3-cycle gaps.
    send_bits(8'h4D, 0, 1'b1, 3);
    chk("gapped_ch_out", 32'(bus.ch_out), 32'h4D);
    chk("gapped_slot", 32'(bus.slot), 32'd0);

    // Test 4: all-ones frame, then mid-frame resync at slot 5.
    send_bits(8'hFF, 0, 1'b1, 0);
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b1, 1'(i == 0));
    chk("pre_resync_slot", 32'(bus.slot), 32'd5);
    err_exp++;
    beat(1'b1, 1'b1, 1'b1);
    chk("resync_ch_hold", 32'(bus.ch_out), 32'hFF);
    chk("resync_frame_err", {30'd0, bus.frame_err, bus.frame_valid}, 32'b10);
    chk("resync_slot", 32'(bus.slot), 32'd1);
    send_bits(8'h0F, 1, 1'b0, 0);
    beat(1'b0, 1'b0, 1'b0);
    chk("after_resync_ch", 32'(bus.ch_out), 32'h0F);

    // Test 5: back-to-back frames, sync only on the first.
    fv_cyc.delete();
    send_bits(8'hA5, 0, 1'b1, 0);
    chk("b2b_first", 32'(bus.ch_out), 32'hA5);
    send_bits(8'h3C, 0, 1'b0, 0);
    chk("b2b_second", 32'(bus.ch_out), 32'h3C);
    beat(1'b0, 1'b0, 1'b0);
    chk("b2b_fv_count", 32'(fv_cyc.size()), 32'd2);
    if (fv_cyc.size() == 2) chk("b2b_fv_spacing", 32'(fv_cyc[1] - fv_cyc[0]), 32'd8);

    // Test 6: asynchronous reset in the middle of a frame.
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 1'(i == 0));
    bus.din = 1'b1; bus.din_valid = 1'b1; bus.sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {20'd0, bus.ch_out, bus.slot, bus.locked}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 1'b1, 1'b0);
      chk($sformatf("post_rst_drop%0d", i), {21'd0, bus.ch_out, bus.locked, bus.slot},
          32'd0);
    end

    repeat (3) beat(1'b0, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("err_all_seen", 32'(err_exp), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_8.md
Name: tdm_demux_1_8

Overview:
- Receive-side counterpart of the 8:1 select mux. Takes one time-multiplexed serial bit stream (slot 0..7 = channel A..H) and distributes each beat to its channel.
- Assembles a full frame in a shadow register, then updates all 8 channel outputs at once with a one-cycle frame strobe.
- Sits at the far end of a TDM link driven by a slot counter plus the 8:1 mux.

Parameters:
- NUM_CH, 8, number of channels (slots per frame); must be a power of 2, ≥2.
- SEL_W, 3, slot counter width = log2(NUM_CH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial TDM data bit.
- din_valid  input  1  din carries a slot beat this cycle.
- sync  input  1  beat is slot 0 (frame start); only meaningful when din_valid=1.
- ch_out  output  NUM_CH  registered channel outputs; bit 0 = A … bit 7 = H.
- frame_valid  output  1  one-cycle pulse; ch_out was updated on the preceding edge.
- frame_err  output  1  one-cycle pulse; resync occurred mid-frame.
- slot  output  SEL_W  slot index expected for the next beat.
- locked  output  1  1 when in RUN.

Behaviour:
- Reset (async assert, sync-release domain = clk):
  - state=IDLE; slot=0; shadow=0.
  - ch_out=0; frame_valid=0; frame_err=0; locked=0.
- State machine: IDLE, RUN.
  - IDLE:
    - A beat (din_valid=1) with sync=0 is dropped.
    - A beat with sync=1: shadow[0]<=din, slot<=1, go to RUN.
  - RUN, no beat: all state holds; gaps of any length allowed.
  - RUN, beat with sync=0: shadow[slot]<=din; slot<=slot+1 (wraps NUM_CH-1 -> 0).
  - RUN, beat with sync=1 and slot==0: normal frame start; same as the sync=0 case.
  - RUN, beat with sync=1 and slot!=0:
    - Partial frame discarded; ch_out unchanged; frame_err pulses next cycle.
    - The beat is taken as slot 0: shadow[0]<=din, slot<=1.
  - Sync is not required on every frame: after slot NUM_CH-1 the block free-runs at slot 0.
- Frame completion (beat with slot==NUM_CH-1, no mid-frame sync):
  - ch_out <= {din, shadow[NUM_CH-2:0]} on that same edge.
  - frame_valid=1 for exactly the following cycle.
  - Latency is 1 clock from the last beat to ch_out/frame_valid visible.
- sync with din_valid=0 is ignored in both states.
- frame_valid and frame_err are mutually exclusive: a mid-frame sync cannot complete a frame.
- ch_out holds its value between frames; shadow bits from an aborted frame never reach ch_out.
- Reset mid-frame: partial frame lost; returns to IDLE; resync needed.
- Back-to-back frames with no gap: frame_valid pulses every NUM_CH cycles.
- locked=1 whenever state==RUN.

Decomposition:
- Shared package holds:
  - NUM_CH/SEL_W defaults;
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1;
  - channel index constants CH_A=0 … CH_H=7, shared with the mux side.
- One natural sub-module: tdm_slot_counter.
  - Modulo-NUM_CH counter with load-to-1-on-sync and advance-on-beat.
  - The transmit side reuses it to drive the 8:1 mux selects.
- Demux shadow/capture logic and the FSM stay in the top module.

Test Plan:
1. Reset release, 8 beats with sync=0 -> all dropped; ch_out=8'h00, locked=0, no frame_valid.
2. sync on the first beat, then 8 consecutive beats carrying bits 1,0,1,1,0,0,1,0 (A..H) -> cycle after beat 8: ch_out=8'b0100_1101, frame_valid pulses once, slot=0.
3. Same frame with din_valid=0 gaps of 3 cycles between beats -> identical ch_out=8'h4D; frame_valid only after the 8th beat.
4. Frame 1 = all ones (ch_out=8'hFF), then frame 2 with sync reasserted at slot 5 -> frame_err pulses; ch_out stays 8'hFF; the following 8 beats of 8'h0F -> ch_out=8'h0F.
5. Two back-to-back frames with sync only on the first (8'hA5 then 8'h3C) -> frame_valid 8 cycles apart; ch_out=8'hA5 then 8'h3C.
6. Assert rst at slot 4 of a frame -> ch_out=0, locked=0 immediately (async); after release, beats without sync are ignored.
